// File: rtl/bitrev_scramble_ctrl.sv
// Scramble RAM controller: loads one natural-order frame through write port A,
// then drains it as bit-reversed butterfly pairs through read ports A/B.
module bitrev_scramble_ctrl #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned MEM_SIZE  = 32,
  parameter int unsigned ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WORD_SIZE-1:0] i_in_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [WORD_SIZE-1:0] o_out_data_A,
  output logic [WORD_SIZE-1:0] o_out_data_B,
  output logic                 o_frame_done,
  output logic                 o_write_en_A,
  output logic [ADDR_SIZE-1:0] o_write_addr_A,
  output logic [WORD_SIZE-1:0] o_write_data_A,
  output logic                 o_read_en_A,
  output logic                 o_read_en_B,
  output logic [ADDR_SIZE-1:0] o_read_addr_A,
  output logic [ADDR_SIZE-1:0] o_read_addr_B,
  input  logic [WORD_SIZE-1:0] i_read_data_A,
  input  logic [WORD_SIZE-1:0] i_read_data_B
);

  localparam int unsigned PAIRS = MEM_SIZE / 2;

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]           state, state_nxt;
  logic [ADDR_SIZE-1:0] wr_cnt, wr_cnt_nxt;
  logic [ADDR_SIZE-1:0] pair_cnt, pair_cnt_nxt;
  logic                 in_ready_q;
  logic                 out_valid_q, out_valid_nxt;
  logic [WORD_SIZE-1:0] out_a_q, out_a_nxt;
  logic [WORD_SIZE-1:0] out_b_q, out_b_nxt;
  logic                 accept;
  logic                 issue;
  logic                 xfer;
  logic                 last_xfer;
  logic [ADDR_SIZE-1:0] even_idx;
  logic [ADDR_SIZE-1:0] odd_idx;

  // Pair k reads natural indices 2k and 2k+1 through a bit-reversing wire swap.
  assign even_idx = {pair_cnt[ADDR_SIZE-2:0], 1'b0};
  assign odd_idx  = {pair_cnt[ADDR_SIZE-2:0], 1'b1};

  for (genvar g = 0; g < ADDR_SIZE; g++) begin : g_rev
    assign o_read_addr_A[g] = even_idx[ADDR_SIZE-1-g];
    assign o_read_addr_B[g] = odd_idx[ADDR_SIZE-1-g];
  end

  // State and datapath registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state       <= ST_LOAD;
      wr_cnt      <= '0;
      pair_cnt    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      state       <= state_nxt;
      wr_cnt      <= wr_cnt_nxt;
      pair_cnt    <= pair_cnt_nxt;
      in_ready_q  <= (state_nxt == ST_LOAD);
      out_valid_q <= out_valid_nxt;
      out_a_q     <= out_a_nxt;
      out_b_q     <= out_b_nxt;
    end
  end

  // Next-state, counters and the output pair register load
  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    pair_cnt_nxt  = pair_cnt;
    out_valid_nxt = out_valid_q;
    out_a_nxt     = out_a_q;
    out_b_nxt     = out_b_q;
    accept        = 1'b0;
    issue         = 1'b0;
    last_xfer     = 1'b0;
    xfer          = out_valid_q & i_out_ready;

    case (state)
      ST_LOAD: begin
        accept = i_in_valid & in_ready_q;
        if (accept) begin
          if (wr_cnt == ADDR_SIZE'(MEM_SIZE - 1)) begin
            wr_cnt_nxt = '0;
            state_nxt  = ST_DRAIN;
          end else begin
            wr_cnt_nxt = wr_cnt + ADDR_SIZE'(1);
          end
        end
      end
      ST_DRAIN: begin
        // pair_cnt counts pairs issued; reaching PAIRS means the frame is fully read.
        issue     = (~out_valid_q | i_out_ready) & (pair_cnt < ADDR_SIZE'(PAIRS));
        last_xfer = xfer & (pair_cnt == ADDR_SIZE'(PAIRS));
        if (issue) begin
          out_a_nxt     = i_read_data_A;
          out_b_nxt     = i_read_data_B;
          out_valid_nxt = 1'b1;
          pair_cnt_nxt  = pair_cnt + ADDR_SIZE'(1);
        end else if (xfer) begin
          out_valid_nxt = 1'b0;
        end
        if (last_xfer) begin
          state_nxt    = ST_LOAD;
          pair_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

  assign o_in_ready     = in_ready_q;
  assign o_write_en_A   = accept;
  assign o_write_addr_A = wr_cnt;
  assign o_write_data_A = i_in_data;
  assign o_read_en_A    = issue;
  assign o_read_en_B    = issue;
  assign o_out_valid    = out_valid_q;
  assign o_out_data_A   = out_a_q;
  assign o_out_data_B   = out_b_q;
  assign o_frame_done   = last_xfer;

endmodule

// File: tb/tb_bitrev_scramble_ctrl.sv
// Bench for bitrev_scramble_ctrl: behavioural dual-port RAM plus queue scoreboards
// for RAM writes and bit-reversed output pairs.
module tb_bitrev_scramble_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned M = 32;
  localparam int unsigned A = 5;
  localparam int unsigned P = M / 2;

  logic         i_CLK = 1'b0;
  logic         i_RST;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [W-1:0] i_in_data;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [W-1:0] o_out_data_A;
  logic [W-1:0] o_out_data_B;
  logic         o_frame_done;
  logic         o_write_en_A;
  logic [A-1:0] o_write_addr_A;
  logic [W-1:0] o_write_data_A;
  logic         o_read_en_A;
  logic         o_read_en_B;
  logic [A-1:0] o_read_addr_A;
  logic [A-1:0] o_read_addr_B;
  logic [W-1:0] i_read_data_A;
  logic [W-1:0] i_read_data_B;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  wr_t   wr_q[$];
  pair_t pair_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic [W-1:0] ram [M];

  always #5 i_CLK = ~i_CLK;

  // Scramble RAM: synchronous write port A, combinational read ports
  always @(posedge i_CLK) if (o_write_en_A) ram[o_write_addr_A] <= o_write_data_A;
  assign i_read_data_A = ram[o_read_addr_A];
  assign i_read_data_B = ram[o_read_addr_B];

  bitrev_scramble_ctrl #(.WORD_SIZE(W), .MEM_SIZE(M)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data_A(o_out_data_A), .o_out_data_B(o_out_data_B),
    .o_frame_done(o_frame_done),
    .o_write_en_A(o_write_en_A), .o_write_addr_A(o_write_addr_A), .o_write_data_A(o_write_data_A),
    .o_read_en_A(o_read_en_A), .o_read_en_B(o_read_en_B),
    .o_read_addr_A(o_read_addr_A), .o_read_addr_B(o_read_addr_B),
    .i_read_data_A(i_read_data_A), .i_read_data_B(i_read_data_B)
  );

  function automatic int rev(input int x);
    int r = 0;
    for (int i = 0; i < int'(A); i++) if ((x >> i) & 1) r = r | (1 << (int'(A) - 1 - i));
    return r;
  endfunction

  // Loads one frame base..base+M-1 and drains it, scoring writes and pairs.
  task automatic frame_run(input logic [W-1:0] base, input bit gap, input int stall_at,
                           input int stall_len, input bit drain_valid);
    int    n = 0;
    int    cyc = 0;
    int    got = 0;
    int    stalls = 0;
    bit    done = 1'b0;
    logic  rdy;
    wr_t   we;
    pair_t pe;
    for (int k = 0; k < int'(M); k++) wr_q.push_back('{addr: A'(k), data: base + W'(k)});
    while (n < int'(M)) begin
      @(negedge i_CLK);
      i_in_valid  = gap ? 1'((cyc % 2) == 0) : 1'b1;
      i_in_data   = base + W'(n);
      i_out_ready = 1'b1;
      #1;
      n_checks++;
      if ({o_in_ready, o_write_en_A, o_out_valid, o_frame_done} !== {1'b1, i_in_valid, 2'b00}) begin
        n_fail++;
        $display("FAIL load_ctrl sample %0d: rdy/we/ov/fd=%b required %b", n,
                 {o_in_ready, o_write_en_A, o_out_valid, o_frame_done}, {1'b1, i_in_valid, 2'b00});
      end
      if (o_write_en_A) begin
        we = wr_q.pop_front();
        n_checks++;
        if ({o_write_addr_A, o_write_data_A} !== {we.addr, we.data}) begin
          n_fail++;
          $display("FAIL write sample %0d: addr=%0d data=%h required addr=%0d data=%h", n,
                   o_write_addr_A, o_write_data_A, we.addr, we.data);
        end
        n++;
      end
      cyc++;
      if (cyc > 4 * int'(M)) begin
        n_checks++; n_fail++;
        $display("FAIL load_timeout: accepted %0d required %0d", n, M);
        return;
      end
    end
    for (int k = 0; k < int'(P); k++)
      pair_q.push_back('{a: base + W'(rev(2 * k)), b: base + W'(rev(2 * k + 1))});
    cyc = 0;
    while (!done) begin
      @(negedge i_CLK);
      i_in_valid  = drain_valid;
      i_in_data   = W'($urandom);
      rdy         = !(got == stall_at && stalls < stall_len);
      i_out_ready = rdy;
      #1;
      n_checks++;
      if ({o_in_ready, o_write_en_A} !== 2'b00) begin
        n_fail++;
        $display("FAIL drain_input: rdy/we=%b required 00", {o_in_ready, o_write_en_A});
      end
      if (cyc == 0) begin
        n_checks++;
        if ({o_out_valid, o_read_en_A, o_read_en_B, o_read_addr_A, o_read_addr_B} !== {3'b011, 5'd0, 5'd16}) begin
          n_fail++;
          $display("FAIL drain_start: ov/enA/enB=%b addrA=%0d addrB=%0d required 011 0 16",
                   {o_out_valid, o_read_en_A, o_read_en_B}, o_read_addr_A, o_read_addr_B);
        end
      end
      if (o_out_valid && rdy) begin
        pe = pair_q.pop_front();
        got++;
        n_checks++;
        if ({o_out_data_A, o_out_data_B, o_frame_done} !== {pe.a, pe.b, 1'(got == int'(P))}) begin
          n_fail++;
          $display("FAIL pair %0d: A=%h B=%h done=%b required A=%h B=%h done=%b", got - 1,
                   o_out_data_A, o_out_data_B, o_frame_done, pe.a, pe.b, 1'(got == int'(P)));
        end
        if (got == int'(P)) done = 1'b1;
      end else begin
        if (o_out_valid && pair_q.size() > 0) begin
          stalls++;
          n_checks++;
          if ({o_out_data_A, o_out_data_B, o_read_en_A, o_read_en_B} !== {pair_q[0].a, pair_q[0].b, 2'b00}) begin
            n_fail++;
            $display("FAIL stall_hold: A=%h B=%h en=%b required A=%h B=%h en=00", o_out_data_A,
                     o_out_data_B, {o_read_en_A, o_read_en_B}, pair_q[0].a, pair_q[0].b);
          end
        end
        n_checks++;
        if (o_frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_done_spurious: got %b required 0 after %0d pairs", o_frame_done, got);
        end
      end
      cyc++;
      if (!done && cyc > 4 * int'(P) + stall_len) begin
        n_checks++; n_fail++;
        $display("FAIL drain_timeout: pairs %0d required %0d", got, P);
        pair_q.delete();
        return;
      end
    end
    n_checks++;
    if (stalls !== stall_len && stall_at >= 0) begin
      n_fail++;
      $display("FAIL stall_count: held %0d cycles required %0d", stalls, stall_len);
    end
  endtask

  task automatic test_reset;
    i_RST = 1'b1; i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b1;
    repeat (3) @(negedge i_CLK);
    i_RST = 1'b0;
    #1;
    n_checks++;
    if ({o_in_ready, o_out_valid, o_frame_done, o_out_data_A, o_out_data_B,
         o_read_en_A, o_read_en_B, o_write_en_A} !== {3'b100, 32'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: rdy/ov/fd=%b A=%h B=%h en=%b required 100 0000 0000 000",
               {o_in_ready, o_out_valid, o_frame_done}, o_out_data_A, o_out_data_B,
               {o_read_en_A, o_read_en_B, o_write_en_A});
    end
  endtask

  task automatic test_basic;
    frame_run(16'h0000, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_gapped_input;
    frame_run(16'h0020, 1'b1, -1, 0, 1'b0);
  endtask

  task automatic test_stall;
    frame_run(16'h0000, 1'b0, 1, 3, 1'b0);
  endtask

  task automatic test_drain_input;
    frame_run(16'h0300, 1'b0, -1, 0, 1'b1);
    frame_run(16'h0400, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_reset_midframe;
    repeat (10) begin
      @(negedge i_CLK);
      i_in_valid = 1'b1;
      i_in_data  = 16'hDEAD;
    end
    @(negedge i_CLK);
    i_in_valid = 1'b0;
    i_RST      = 1'b1;
    @(negedge i_CLK);
    #1;
    n_checks++;
    if ({o_in_ready, o_out_valid, o_frame_done, o_write_en_A} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_mid: rdy/ov/fd/we=%b required 1000",
               {o_in_ready, o_out_valid, o_frame_done, o_write_en_A});
    end
    i_RST = 1'b0;
    frame_run(16'h0100, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    frame_run(16'h0500, 1'b0, -1, 0, 1'b0);
    frame_run(16'h0600, 1'b0, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gapped_input;
    test_stall;
    test_drain_input;
    test_reset_midframe;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
